cmd_frame_parser: RTL and testbench
===================================

# cmd_frame_parser

- Sits between the UART byte receiver and the flight-control target mapping.
- Assembles serial bytes into fixed 5-byte command frames and validates each frame's XOR checksum.
- Presents the command code and a 16-bit parameter with a one-cycle strobe.
- Flags framing errors and asserts a link-lost failsafe flag when no valid frame arrives within a configurable window.

## Interface
- `HEADER`, 8'hAA: frame start byte.
- `GAP_CYCLES`, 50000: maximum idle clock cycles between bytes inside a frame (1 ms at 50 MHz).
- `LINK_TIMEOUT`, 25000000: cycles without a valid frame before `link_lost` is set (0.5 s at 50 MHz).
- `clk`  in  1  system clock (50 MHz).
- `rst_n`  in  1  reset, synchronous, active-high (asserted = 1).
- `rx_data_ready`  in  1  one-cycle strobe from the UART receiver: `rx_data` is valid.
- `rx_data`  in  8  received byte.
- `cmd_valid`  out  1  one-cycle strobe: a new validated frame is on `cmd_code`/`cmd_param`.
- `cmd_code`  out  8  command byte of the last valid frame.
- `cmd_param`  out  16  parameter {hi, lo} of the last valid frame.
- `err_pulse`  out  1  one-cycle strobe: a frame was discarded.
- `err_code`  out  2  reason for the last discard:
  - 01: checksum
  - 10: inter-byte timeout
  - 11: command rejected
- `link_lost`  out  1  no valid frame within `LINK_TIMEOUT`.

## Operation
- Frame format, in order: `HEADER`, CMD, P_HI, P_LO, CHK. The frame is valid when CHK == CMD ^ P_HI ^ P_LO.
- FSM states: HUNT, GET_CMD, GET_PHI, GET_PLO, GET_CHK.
  - HUNT: a byte equal to `HEADER` moves to GET_CMD. Any other byte is silently dropped, with no error.
  - GET_CMD, GET_PHI, GET_PLO: each byte is latched into a shadow register and the FSM advances. A byte equal to `HEADER` is treated as data (no resync).
  - GET_CHK: on a byte, the FSM returns to HUNT.
    - Checksum match (and filter pass, see Configuration): load `cmd_code`/`cmd_param` from the shadows and pulse `cmd_valid`.
    - Checksum mismatch: pulse `err_pulse` with `err_code`=01.
- The checksum is a running XOR: cleared on entry to GET_CMD, updated with CMD, P_HI and P_LO.
- Gap counter:
  - Cleared on every `rx_data_ready`. Held at 0 in HUNT. Otherwise increments each cycle.
  - Abort: in any non-HUNT state, on the edge where the counter == `GAP_CYCLES`-1 and no byte arrives, go to HUNT and pulse `err_pulse` with `err_code`=10. Partial shadows are discarded.
- Link counter:
  - Increments every cycle and saturates. Cleared on the edge that asserts `cmd_valid`.
  - `link_lost` is set on the edge where the counter reaches `LINK_TIMEOUT`-1.
  - `link_lost` is cleared on the same edge that asserts `cmd_valid`.
- Counter widths are `$clog2(param)+1`. Arithmetic is unsigned.
- Reset values:
  - State HUNT; all counters 0.
  - `cmd_valid`=0, `cmd_code`=0, `cmd_param`=0, `err_pulse`=0, `err_code`=00.
  - `link_lost`=1 (no link yet).

## Timing
- `cmd_valid` is high exactly one cycle, on the edge after the CHK byte's `rx_data_ready` cycle: one cycle of latency. `cmd_code`/`cmd_param` change only on that edge and hold until the next valid frame.
- `err_pulse` is one cycle wide and registered alongside `err_code`. `err_code` holds until the next error.
- `cmd_valid` and `err_pulse` are never high together.
- Byte and gap expiry in the same cycle: the byte wins. It is processed and the gap counter clears.
- Valid frame and link expiry in the same cycle: the frame wins. `link_lost` ends at 0.
- Reset asserted mid-frame: on the next edge all state returns to reset values. Partial frames are lost, with no error pulse.
- Back-to-back frames with no gap are accepted. Minimum spacing is one byte strobe per cycle.

## Configuration
- `CMD_FILTER_EN` defined: a frame with a good checksum is accepted only if CMD is in 8'h01..8'h03.
  - Any other CMD gives `err_pulse` with `err_code`=11, no `cmd_valid`, and no link counter clear.
- `CMD_FILTER_EN` undefined: any CMD with a good checksum is accepted. `err_code` 11 never occurs.

## Test plan
All scenarios use `GAP_CYCLES`=20 and `LINK_TIMEOUT`=200.

- Bytes AA 03 01 F4 F6 -> one `cmd_valid` pulse one cycle after the F6 strobe; `cmd_code`=03, `cmd_param`=16'h01F4; `link_lost` 1->0.
- Bytes AA 01 00 00 02 (bad CHK) -> `err_pulse` with `err_code`=01; `cmd_code`/`cmd_param` unchanged; back in HUNT.
- Bytes 55 12 AA 02 00 00 02 -> leading garbage ignored, no error; `cmd_valid` with `cmd_code`=02.
- Bytes AA 01, then 20 idle cycles -> `err_pulse` with `err_code`=10 on the 20th cycle after the 01 strobe. A following AA 01 03 E8 EA -> valid, `cmd_param`=16'h03E8.
- After a valid frame, no traffic for 200 cycles -> `link_lost`=1 on the 200th edge. Reset pulse mid-frame (after AA 01) -> all outputs return to reset values; the next full frame is accepted.
- With `CMD_FILTER_EN`: AA 07 00 00 07 -> `err_code`=11, no `cmd_valid`. Without `CMD_FILTER_EN`: the same frame -> `cmd_valid` with `cmd_code`=07.

Source files
------------

// File: rtl/cmd_frame_parser.sv
// Turns UART bytes into validated 5-byte command frames with an XOR checksum.
// The link-lost failsafe flag is built in. Define CMD_FILTER_EN to accept only CMD 8'h01..8'h03.
module cmd_frame_parser #(
    parameter logic [7:0]  HEADER       = 8'hAA,
    parameter int unsigned GAP_CYCLES   = 50000,
    parameter int unsigned LINK_TIMEOUT = 25000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_data_ready,
    input  logic [7:0]  rx_data,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic [15:0] cmd_param,
    output logic        err_pulse,
    output logic [1:0]  err_code,
    output logic        link_lost,
    output logic [2:0]  dbg_state
);

    localparam int GAP_W  = $clog2(GAP_CYCLES) + 1;
    localparam int LINK_W = $clog2(LINK_TIMEOUT) + 1;
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [LINK_W-1:0] LINK_LAST = LINK_W'(LINK_TIMEOUT - 1);

    localparam logic [1:0] ERR_CHK = 2'b01;
    localparam logic [1:0] ERR_GAP = 2'b10;
    localparam logic [1:0] ERR_CMD = 2'b11;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        GET_CMD = 3'd1,
        GET_PHI = 3'd2,
        GET_PLO = 3'd3,
        GET_CHK = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [LINK_W-1:0]   link_cnt_q, link_cnt_d;
    logic [7:0]          chk_q, chk_d;
    logic [7:0]          cmd_sh_q, cmd_sh_d;
    logic [7:0]          phi_sh_q, phi_sh_d;
    logic [7:0]          plo_sh_q, plo_sh_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic [7:0]          cmd_code_q, cmd_code_d;
    logic [15:0]         cmd_param_q, cmd_param_d;
    logic                err_pulse_q, err_pulse_d;
    logic [1:0]          err_code_q, err_code_d;
    logic                link_lost_q, link_lost_d;
    logic                cmd_ok;

    // Handshake: rx_data is consumed only in a cycle where rx_data_ready is high;
    // cmd_valid and err_pulse are single-cycle strobes with no backpressure.
    always_comb begin
`ifdef CMD_FILTER_EN
        cmd_ok = (cmd_sh_q >= 8'h01) && (cmd_sh_q <= 8'h03);
`else
        cmd_ok = 1'b1;
`endif
    end

    always_comb begin
        state_d     = state_q;
        chk_d       = chk_q;
        cmd_sh_d    = cmd_sh_q;
        phi_sh_d    = phi_sh_q;
        plo_sh_d    = plo_sh_q;
        cmd_code_d  = cmd_code_q;
        cmd_param_d = cmd_param_q;
        err_code_d  = err_code_q;
        cmd_valid_d = 1'b0;
        err_pulse_d = 1'b0;
        link_lost_d = link_lost_q;

        if (rx_data_ready || state_q == HUNT) begin
            gap_cnt_d = '0;
        end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
        end

        if (link_cnt_q != LINK_LAST) begin
            link_cnt_d = link_cnt_q + 1'b1;
        end else begin
            link_cnt_d = link_cnt_q;
        end
        if (link_cnt_d == LINK_LAST) begin
            link_lost_d = 1'b1;
        end

        if (rx_data_ready) begin
            case (state_q)
                HUNT: begin
                    if (rx_data == HEADER) begin
                        state_d = GET_CMD;
                        chk_d   = 8'h00;
                    end
                end
                GET_CMD: begin
                    cmd_sh_d = rx_data;
                    chk_d    = chk_q ^ rx_data;
                    state_d  = GET_PHI;
                end
                GET_PHI: begin
                    phi_sh_d = rx_data;
                    chk_d    = chk_q ^ rx_data;
                    state_d  = GET_PLO;
                end
                GET_PLO: begin
                    plo_sh_d = rx_data;
                    chk_d    = chk_q ^ rx_data;
                    state_d  = GET_CHK;
                end
                GET_CHK: begin
                    state_d = HUNT;
                    if (rx_data == chk_q && cmd_ok) begin
                        cmd_valid_d = 1'b1;
                        cmd_code_d  = cmd_sh_q;
                        cmd_param_d = {phi_sh_q, plo_sh_q};
                        link_cnt_d  = '0;
                        link_lost_d = 1'b0;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_code_d  = (rx_data != chk_q) ? ERR_CHK : ERR_CMD;
                    end
                end
                default: state_d = HUNT;
            endcase
        end else if (state_q != HUNT && gap_cnt_q == GAP_LAST) begin
            // A byte arriving on the expiry cycle takes the branch above instead.
            state_d     = HUNT;
            err_pulse_d = 1'b1;
            err_code_d  = ERR_GAP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= HUNT;
            gap_cnt_q   <= '0;
            link_cnt_q  <= '0;
            chk_q       <= 8'h00;
            cmd_sh_q    <= 8'h00;
            phi_sh_q    <= 8'h00;
            plo_sh_q    <= 8'h00;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= 8'h00;
            cmd_param_q <= 16'h0000;
            err_pulse_q <= 1'b0;
            err_code_q  <= 2'b00;
            link_lost_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            link_cnt_q  <= link_cnt_d;
            chk_q       <= chk_d;
            cmd_sh_q    <= cmd_sh_d;
            phi_sh_q    <= phi_sh_d;
            plo_sh_q    <= plo_sh_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            cmd_param_q <= cmd_param_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
            link_lost_q <= link_lost_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_code  = cmd_code_q;
    assign cmd_param = cmd_param_q;
    assign err_pulse = err_pulse_q;
    assign err_code  = err_code_q;
    assign link_lost = link_lost_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Bench for cmd_frame_parser: directed frames from the test plan followed by random traffic.
// A frame-level reference model and an expected-frame queue check every output.
module tb_cmd_frame_parser;

    localparam int GAP = 20;
    localparam int LT  = 200;
    localparam logic [7:0] HDR = 8'hAA;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rx_data_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic [15:0] cmd_param;
    logic        err_pulse;
    logic [1:0]  err_code;
    logic        link_lost;
    logic [2:0]  dbg_state;

    cmd_frame_parser #(.HEADER(HDR), .GAP_CYCLES(GAP), .LINK_TIMEOUT(LT)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data_ready(rx_data_ready), .rx_data(rx_data),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_param(cmd_param),
        .err_pulse(err_pulse), .err_code(err_code), .link_lost(link_lost),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: bytes collected after a header, idle time inside a frame,
    // and age of the link since the last accepted frame.
    bit          m_in_frame = 1'b0;
    logic [7:0]  m_buf[$];
    int          m_gap = 0;
    int          m_age = 0;
    logic        m_valid = 1'b0;
    logic        m_err = 1'b0;
    logic [1:0]  m_ecode = 2'b00;
    logic [7:0]  m_code = 8'h00;
    logic [15:0] m_param = 16'h0000;
    logic        m_lost = 1'b1;
    logic [23:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit cmd_accepted(input logic [7:0] c);
`ifdef CMD_FILTER_EN
        return (c >= 8'h01) && (c <= 8'h03);
`else
        return (c == c);
`endif
    endfunction

    task automatic model_edge(input bit rst, input bit rdy, input logic [7:0] d);
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (rst) begin
            m_in_frame = 1'b0;
            m_buf.delete();
            m_gap = 0; m_age = 0;
            m_ecode = 2'b00; m_code = 8'h00; m_param = 16'h0000; m_lost = 1'b1;
            return;
        end
        if (rdy) begin
            if (!m_in_frame) begin
                if (d == HDR) begin
                    m_in_frame = 1'b1;
                    m_buf.delete();
                    m_gap = 0;
                end
            end else begin
                m_buf.push_back(d);
                m_gap = 0;
                if (m_buf.size() == 4) begin
                    m_in_frame = 1'b0;
                    if ((m_buf[0] ^ m_buf[1] ^ m_buf[2]) != m_buf[3]) begin
                        m_err = 1'b1; m_ecode = 2'b01;
                    end else if (!cmd_accepted(m_buf[0])) begin
                        m_err = 1'b1; m_ecode = 2'b11;
                    end else begin
                        m_valid = 1'b1;
                        m_code  = m_buf[0];
                        m_param = {m_buf[1], m_buf[2]};
                        exp_q.push_back({m_code, m_param});
                    end
                end
            end
        end else if (m_in_frame) begin
            m_gap++;
            if (m_gap == GAP) begin
                m_in_frame = 1'b0;
                m_err = 1'b1; m_ecode = 2'b10;
            end
        end
        if (m_valid) begin
            m_age  = 0;
            m_lost = 1'b0;
        end else begin
            if (m_age < LT - 1) m_age++;
            if (m_age == LT - 1) m_lost = 1'b1;
        end
    endtask

    task automatic check_outputs();
        logic [23:0] exp_frame;
        check_eq("cmd_valid", cmd_valid, m_valid);
        check_eq("err_pulse", err_pulse, m_err);
        check_eq("err_code", err_code, m_ecode);
        check_eq("cmd_code", cmd_code, m_code);
        check_eq("cmd_param", cmd_param, m_param);
        check_eq("link_lost", link_lost, m_lost);
        check_eq("hunting", dbg_state == 3'd0, !m_in_frame);
        if (cmd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_unexpected_frame", {cmd_code, cmd_param}, 32'hFFFF_FFFF);
            end else begin
                exp_frame = exp_q.pop_front();
                check_eq("sb_frame", {cmd_code, cmd_param}, exp_frame);
            end
        end
    endtask

    task automatic step(input bit rst, input bit rdy, input logic [7:0] d);
        @(negedge clk);
        rst_n = rst;
        rx_data_ready = rdy;
        rx_data = rdy ? d : 8'($urandom_range(0, 255));
        @(posedge clk);
        #1;
        model_edge(rst, rdy, d);
        check_outputs();
    endtask

    task automatic send_byte(input logic [7:0] d);
        step(1'b0, 1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] ph, input logic [7:0] pl,
                              input logic [7:0] ck, input int max_gap);
        logic [7:0] bytes[5];
        bytes[0] = HDR; bytes[1] = c; bytes[2] = ph; bytes[3] = pl; bytes[4] = ck;
        for (int i = 0; i < 5; i++) begin
            send_byte(bytes[i]);
            if (i < 4) idle($urandom_range(0, max_gap));
        end
    endtask

    initial begin
        logic [7:0] c, ph, pl, ck;
        int kind;

        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);

        send_frame(8'h03, 8'h01, 8'hF4, 8'hF6, 0);
        idle(3);
        send_frame(8'h01, 8'h00, 8'h00, 8'h02, 0);
        idle(2);
        send_byte(8'h55);
        send_byte(8'h12);
        send_frame(8'h02, 8'h00, 8'h00, 8'h02, 0);
        idle(2);
        send_byte(HDR);
        send_byte(8'h01);
        idle(GAP);
        send_frame(8'h01, 8'h03, 8'hE8, 8'hEA, 0);
        idle(LT + 10);
        send_frame(8'h01, 8'h00, 8'h05, 8'h04, 0);
        send_byte(HDR);
        send_byte(8'h01);
        step(1'b1, 1'b0, 8'h00);
        send_frame(8'h02, 8'h00, 8'h10, 8'h12, 0);
        send_frame(8'h07, 8'h00, 8'h00, 8'h07, 0);
        send_frame(8'h01, HDR, HDR, 8'h01, 0);
        idle(2);

        for (int it = 0; it < 400; it++) begin
            kind = $urandom_range(0, 11);
            c  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 3)) : 8'($urandom_range(0, 255));
            ph = 8'($urandom_range(0, 255));
            pl = 8'($urandom_range(0, 255));
            ck = c ^ ph ^ pl;
            case (kind)
                0, 1, 2, 3: send_frame(c, ph, pl, ck, $urandom_range(0, 2));
                4:          send_frame(c, ph, pl, ck ^ 8'($urandom_range(1, 255)), 1);
                5:          send_byte(8'($urandom_range(0, 255)));
                6:          idle($urandom_range(0, 4));
                7: begin
                    send_byte(HDR);
                    for (int k = 0; k < int'($urandom_range(0, 3)); k++) send_byte(8'($urandom_range(0, 255)));
                    idle($urandom_range(GAP - 2, GAP + 2));
                end
                8:          send_frame(c, ph, pl, ck, GAP - 1);
                9:          if ($urandom_range(0, 9) == 0) idle($urandom_range(LT - 5, LT + 5));
                10: begin
                    send_byte(HDR);
                    send_byte(c);
                    step(1'b1, 1'b0, 8'h00);
                end
                default:    send_frame(c, ph, pl, ck, 0);
            endcase
        end
        idle(GAP + 2);
        check_eq("sb_leftover", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
